alu_mdu: RTL and testbench

Parametrised execute-stage arithmetic unit for the RISC-V pipeline: performs all base-integer ALU operations plus the RV32M multiply/divide group. Single-cycle ALU ops return one cycle after acceptance; multiply/divide run iteratively over XLEN cycles. A valid/ready handshake on both sides lets the hazard unit stall EX while a long op is in flight.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_mdu_mdu_iter.sv | 117 +++++++++++
 rtl/alu_mdu.sv | 123 ++++++++++++
 tb/tb_alu_mdu.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and decode helpers
// shared by the execute-stage arithmetic unit.
package alu_pkg;

  localparam logic [4:0] OP_SLL    = 5'h00;
  localparam logic [4:0] OP_SRL    = 5'h01;
  localparam logic [4:0] OP_SRA    = 5'h02;
  localparam logic [4:0] OP_ADD    = 5'h03;
  localparam logic [4:0] OP_SUB    = 5'h04;
  localparam logic [4:0] OP_XOR    = 5'h05;
  localparam logic [4:0] OP_OR     = 5'h06;
  localparam logic [4:0] OP_AND    = 5'h07;
  localparam logic [4:0] OP_SLT    = 5'h08;
  localparam logic [4:0] OP_SLTU   = 5'h09;
  localparam logic [4:0] OP_LUI    = 5'h0A;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  function automatic logic is_muldiv(
    input logic [4:0] op
  );
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_div(
    input logic [4:0] op
  );
    return is_muldiv(op) && op[2];
  endfunction

endpackage

// File: rtl/alu_mdu_mdu_iter.sv
// mdu_iter: iterative shift-add multiplier and
// restoring divider on operand magnitudes.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [2:0]      i_fn,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic              r_run;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_fn;
  logic              r_sa;
  logic              r_sb;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;

  logic              w_a_sgn;
  logic              w_b_sgn;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shl;
  logic [XLEN:0]     w_dif;
  logic [2*XLEN-1:0] w_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  // fn: 000 MUL 001 MULH 010 MULHSU 011 MULHU
  //     100 DIV 101 DIVU 110 REM    111 REMU
  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    if (i_fn[2]) begin
      w_a_sgn = !i_fn[0] && i_a[XLEN-1];
      w_b_sgn = !i_fn[0] && i_b[XLEN-1];
    end else begin
      w_a_sgn = (i_fn[1:0] == 2'b01 ||
                 i_fn[1:0] == 2'b10) && i_a[XLEN-1];
      w_b_sgn = (i_fn[1:0] == 2'b01) && i_b[XLEN-1];
    end
    w_a_mag = w_a_sgn ? -i_a : i_a;
    w_b_mag = w_b_sgn ? -i_b : i_b;
  end

  // r_acc holds {hi, lo}: {partial, multiplier}
  // for mul and {remainder, quotient} for div.
  always_comb begin
    w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} +
            (r_acc[0] ? {1'b0, r_b} : '0);
    w_shl = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_dif = w_shl - {1'b0, r_b};
    if (r_fn[2]) begin
      w_next = {w_dif[XLEN] ? w_shl[XLEN-1:0]
                            : w_dif[XLEN-1:0],
                r_acc[XLEN-2:0], !w_dif[XLEN]};
    end else begin
      w_next = {w_sum, r_acc[XLEN-1:1]};
    end
    w_prod = (r_sa ^ r_sb) ? -w_next : w_next;
    w_quo  = (r_sa ^ r_sb) ? -w_next[XLEN-1:0]
                           : w_next[XLEN-1:0];
    w_rem  = r_sa ? -w_next[2*XLEN-1:XLEN]
                  : w_next[2*XLEN-1:XLEN];
    if (r_fn[2]) begin
      o_result = r_fn[1] ? w_rem : w_quo;
    end else if (r_fn[1:0] == 2'b00) begin
      o_result = w_prod[XLEN-1:0];
    end else begin
      o_result = w_prod[2*XLEN-1:XLEN];
    end
  end

  assign o_done = r_run && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_fn  <= '0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_flush) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_fn  <= i_fn;
      r_sa  <= w_a_sgn;
      r_sb  <= w_b_sgn;
      r_b   <= w_b_mag;
      r_acc <= {{XLEN{1'b0}}, w_a_mag};
    end else if (r_run) begin
      r_acc <= w_next;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU plus RV32M unit with
// valid/ready on both sides and a registered result.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t             r_state;
  state_t             w_nstate;
  logic [XLEN-1:0]    r_result;
  logic [XLEN-1:0]    w_alu;
  logic [SHAMT_W-1:0] w_sh;
  logic               w_acc;
  logic               w_iter;
  logic               w_div0;
  logic               w_ovf;
  logic               w_mdu_done;
  logic [XLEN-1:0]    w_mdu_res;

  assign in_ready = !flush &&
    (r_state == S_IDLE ||
     (r_state == S_DONE && out_ready));
  assign w_acc  = in_valid && in_ready;
  assign w_sh   = op_b[SHAMT_W-1:0];
  assign w_div0 = (op_b == '0);
  assign w_ovf  = (in_op == OP_DIV || in_op == OP_REM) &&
                  op_a == MIN && op_b == '1;
  // divide corner cases finish at ALU latency
  assign w_iter = w_acc && is_muldiv(in_op) &&
                  !(is_div(in_op) && (w_div0 || w_ovf));

  always_comb begin
    w_alu = '0;
    unique case (in_op)
      OP_SLL:  w_alu = op_a << w_sh;
      OP_SRL:  w_alu = op_a >> w_sh;
      OP_SRA:  w_alu = $signed(op_a) >>> w_sh;
      OP_ADD:  w_alu = op_a + op_b;
      OP_SUB:  w_alu = op_a - op_b;
      OP_XOR:  w_alu = op_a ^ op_b;
      OP_OR:   w_alu = op_a | op_b;
      OP_AND:  w_alu = op_a & op_b;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}},
                        $signed(op_a) < $signed(op_b)};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_LUI:  w_alu = op_b;
      OP_DIV, OP_DIVU:
        w_alu = w_div0 ? '1 : op_a;
      OP_REM, OP_REMU:
        w_alu = w_div0 ? op_a : '0;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    if (flush) begin
      w_nstate = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (w_acc) w_nstate = w_iter ? S_BUSY : S_DONE;
        S_BUSY:
          if (w_mdu_done) w_nstate = S_DONE;
        S_DONE:
          if (out_ready)
            w_nstate = !w_acc ? S_IDLE :
                       w_iter ? S_BUSY : S_DONE;
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_result <= '0;
    end else begin
      r_state <= w_nstate;
      if (!flush) begin
        if (w_acc && !w_iter) r_result <= w_alu;
        else if (w_mdu_done)  r_result <= w_mdu_res;
      end
    end
  end

  mdu_iter #(
    .XLEN (XLEN)
  ) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_flush  (flush),
    .i_start  (w_iter),
    .i_fn     (in_op[2:0]),
    .i_a      (op_a),
    .i_b      (op_b),
    .o_done   (w_mdu_done),
    .o_result (w_mdu_res)
  );

  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state == S_BUSY);
  assign out_result = r_result;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: random + directed stimulus, queue
// scoreboard against an arithmetic reference model.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [4:0]  in_op = 0;
  logic [31:0] op_a = 0;
  logic [31:0] op_b = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] out_result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int b_lo = 1;
  int b_hi = 0;
  int first = 0;
  int last_acc = 0;
  bit seen = 0;
  bit rnd_rdy = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  alu_mdu #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [4:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    longint p;
    logic [63:0] u;
    int sh;
    sa = a;
    sb = b;
    sh = int'(b[4:0]);
    case (op)
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return sa >>> sh;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_SLT:  return {31'b0, sa < sb};
      OP_SLTU: return {31'b0, a < b};
      OP_LUI:  return b;
      OP_MUL: begin
        p = longint'(sa) * longint'(sb);
        return p[31:0];
      end
      OP_MULH: begin
        p = longint'(sa) * longint'(sb);
        return p[63:32];
      end
      OP_MULHSU: begin
        p = longint'(sa) * longint'({32'b0, b});
        return p[63:32];
      end
      OP_MULHU: begin
        u = {32'b0, a} * {32'b0, b};
        return u[63:32];
      end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return a;
        return sa / sb;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 0;
        return sa % sb;
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_lat(
    input logic [4:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    bit sgn_div;
    sgn_div = (op == OP_DIV || op == OP_REM);
    if (op < OP_MUL || op > OP_REMU) return 1;
    if (op >= OP_DIV && b == 0) return 1;
    if (sgn_div && a == 32'h8000_0000 &&
        b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic issue(input logic [4:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bit done;
    int t;
    exp_t e;
    done = 0;
    t = 0;
    in_valid = 1;
    in_op = op;
    op_a = a;
    op_b = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = model(op, a, b);
        e.lat = exp_lat(op, a, b);
        e.acc = cyc + 1;
        q.push_back(e);
        last_acc = cyc + 1;
        if (e.lat > 1) begin
          b_lo = cyc + 1;
          b_hi = cyc + XLEN;
        end
        done = 1;
      end else if (t >= 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: op %h never accepted",
                 op);
        done = 1;
      end
      t++;
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic idle();
    in_valid = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid = 0;
    out_ready = 1;
    while (q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, want 0",
               q.size());
      q.delete();
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (flush) chk("flush_in_ready", {31'b0, in_ready}, 0);
      chk("busy", {31'b0, busy},
          {31'b0, (cyc >= b_lo && cyc <= b_hi)});
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: result %h, none expected",
                   out_result);
        end else begin
          if (!seen) begin
            seen = 1;
            first = cyc;
          end
          if (out_ready) begin
            e = q.pop_front();
            chk("result", out_result, e.res);
            chk("latency", 32'(first - e.acc + 1), 32'(e.lat));
            seen = 0;
          end else begin
            chk("hold_result", out_result, q[0].res);
            chk("hold_in_ready", {31'b0, in_ready}, 0);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [4:0] op;
    wait_cyc(2);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rst_n = 1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    wait_cyc(1);

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    issue(OP_SRA, 32'h8000_0000, 32'd4);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
    issue(OP_LUI, 32'h1234_5678, 32'hABCD_E000);
    issue(5'h1F, 32'h1, 32'h2);
    issue(OP_MULH, 32'h8000_0000, 32'h8000_0000);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(OP_DIV, -32'sd7, 32'd2);
    issue(OP_REM, -32'sd7, 32'd2);
    issue(OP_DIVU, 32'd7, 32'd0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_ADD, 32'd10, 32'd20);
    issue(OP_SUB, 32'd5, 32'd9);
    issue(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    idle();
    drain();

    out_ready = 0;
    issue(OP_ADD, 32'd3, 32'd4);
    idle();
    wait_cyc(5);
    out_ready = 1;
    drain();

    issue(OP_DIVU, 32'hDEAD_BEEF, 32'd7);
    idle();
    wait_cyc(9);
    flush = 1;
    in_valid = 1;
    in_op = OP_ADD;
    op_a = 32'd1;
    op_b = 32'd2;
    @(negedge clk);
    if (q.size() > 0) void'(q.pop_front());
    seen = 0;
    b_hi = cyc;
    @(posedge clk);
    #1;
    flush = 0;
    in_valid = 0;
    issue(OP_ADD, 32'd100, 32'd23);
    idle();
    drain();

    issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    idle();
    wait_cyc(5);
    #2;
    rst_n = 0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 0);
    chk("arst_out_result", out_result, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    q.delete();
    seen = 0;
    b_lo = 1;
    b_hi = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    chk("arst_in_ready", {31'b0, in_ready}, 1);
    wait_cyc(1);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle();
    drain();

    rnd_rdy = 1;
    for (int i = 0; i < 200; i++) begin
      n = $urandom_range(0, 23);
      if (n < 11) op = 5'(n);
      else if (n < 19) op = 5'(16 + n - 11);
      else if (n < 21) op = 5'(11 + $urandom_range(0, 4));
      else op = 5'(24 + $urandom_range(0, 7));
      issue(op, rnd_opnd(), rnd_opnd());
      if ($urandom_range(0, 3) == 0) begin
        idle();
        wait_cyc($urandom_range(1, 3));
      end
    end
    rnd_rdy = 0;
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
